// File: rtl/div_pkg.sv
// Shared types, constants and sign helpers for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Magnitude as an unsigned value, so -2^(W-1) maps to 2^(W-1) without overflow.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x,
                                                     input logic               is_signed);
        return (is_signed && x[DIV_WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] x,
                                                    input logic               neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract, restore or keep.
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The extra bit keeps the shifted remainder exact and gives the trial its sign.
    assign shifted = {r_i, q_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_i};

    assign r_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; one trial subtraction per clock.
// Define DIV_EARLY_OUT_EN to skip the iterations when |dividend| < |divisor| or divisor == 0.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] step_r, step_q;
    logic [WIDTH-1:0] fin_r, fin_q;
    logic             early_out;

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dvs_q),
        .r_o (step_r),
        .q_o (step_q)
    );

`ifdef DIV_EARLY_OUT_EN
    // Evaluated on the first CALC cycle, while q_q still holds |dividend| and r_q is zero.
    assign early_out = (cnt_q == '0) && (dbz_q || (q_q < dvs_q));
`else
    assign early_out = 1'b0;
`endif

    assign fin_q = early_out ? '0  : step_q;
    assign fin_r = early_out ? q_q : step_r;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    r_d     = '0;
                    q_d     = abs_val(dividend, is_signed);
                    dvs_d   = abs_val(divisor, is_signed);
                    q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = is_signed && dividend[WIDTH-1];
                    dbz_d   = (divisor == '0);
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (early_out || cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        // With a zero divisor R ends as |dividend|, so only Q needs forcing.
                        quot_d  = dbz_q ? ALL_ONES : neg_if(fin_q, q_neg_q);
                        rem_d   = neg_if(fin_r, r_neg_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus random DIV/DIVU
// against an arithmetic reference model.
module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    always #5 clk = ~clk;

    iter_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        longint sa, sb, mq, mr, ma, mb;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            mq = sa / sb;
            mr = sa % sb;
            q  = mq[W-1:0];
            r  = mr[W-1:0];
        end
        lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
        if (b == '0 || ma < mb) lat = 2;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input string tag, input bit inject);
        logic [W-1:0] eq, er;
        int elat, lat, nbusy;
        bit seen;
        model(a, b, sgn, eq, er, elat);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; nbusy = 0; seen = 1'b0;
        while (lat <= 100) begin
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inject && lat == 1) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(elat));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int ndone;
        logic [W-1:0] a, b;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, "divu_100_7", 1'b0);
        run_op(-32'sd7, 32'd2, 1'b1, "div_m7_2", 1'b0);
        run_op(32'd7, -32'sd2, 1'b1, "div_7_m2", 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1", 1'b0);
        run_op(32'h1234, 32'd0, 1'b0, "divu_by_zero", 1'b1);
        run_op(32'hFFFF_FF00, 32'd0, 1'b1, "div_by_zero_neg", 1'b0);
        run_op(32'd3, 32'd10, 1'b0, "divu_3_10", 1'b0);

        // Cancel in the middle of CALC: no done and previous results hold.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("cancel no_done", 32'(ndone), 32'd0);
        check("cancel busy", 32'(busy), 32'd0);
        check("cancel quotient_kept", quotient, last_q);
        check("cancel remainder_kept", remainder, last_r);

        // Cancel together with start in IDLE drops the request.
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start busy", 32'(busy), 32'd0);

        run_op(32'd9, 32'd3, 1'b0, "divu_9_3", 1'b0);

        // Asynchronous reset during CALC.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst done", 32'(done), 32'd0);
        check("async_rst quotient", quotient, '0);
        check("async_rst remainder", remainder, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("async_rst no_done", 32'(ndone), 32'd0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'd0;
                default: b = -32'($urandom_range(1, 15));
            endcase
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(a, b, 1'($urandom), $sformatf("rand%0d", i), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
